// File: rtl/divisor_parametrico_if.sv
// Operand/result bundle for divisor_parametrico: request side (Start, Signo, Num, Den) and result side.
// master drives requests and reads results; slave is the divider.
interface divisor_parametrico_if #(
  parameter int TAMANYO = 32
);
  logic               Start;
  logic               Signo;
  logic [TAMANYO-1:0] Num;
  logic [TAMANYO-1:0] Den;
  logic [TAMANYO-1:0] Coc;
  logic [TAMANYO-1:0] Res;
  logic               Done;
  logic               Busy;
  logic               Ovf;
  logic               DivCero;

  modport master (
    output Start, Signo, Num, Den,
    input  Coc, Res, Done, Busy, Ovf, DivCero
  );

  modport slave (
    input  Start, Signo, Num, Den,
    output Coc, Res, Done, Busy, Ovf, DivCero
  );
endinterface

// File: rtl/divisor_parametrico.sv
// Iterative restoring divider, signed/unsigned; Done pulses TAMANYO+1 edges after accept, Start ignored while Busy.
// Optional DIVISOR_DIV_CERO_DETECT_EN: zero divisor skips iteration, Done 2 edges after accept with DivCero=1.
module divisor_parametrico #(
  parameter int TAMANYO = 32
) (
  input logic                  CLK,
  input logic                  RSTa,
  divisor_parametrico_if.slave bus
);
  localparam int CW = $clog2(TAMANYO);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             r_state;
  logic               r_signo;
  logic               r_sn;
  logic               r_sd;
  logic               r_ovf_pend;
  logic               r_done;
  logic               r_ovf;
  logic [TAMANYO-1:0] r_accu;
  logic [TAMANYO-1:0] r_q;
  logic [TAMANYO-1:0] r_m;
  logic [TAMANYO-1:0] r_coc;
  logic [TAMANYO-1:0] r_res;
  logic [CW-1:0]      r_cnt;

  logic               w_num_neg;
  logic               w_den_neg;
  logic               w_ovf_in;
  logic               w_ge;
  logic [TAMANYO-1:0] w_num_mag;
  logic [TAMANYO-1:0] w_den_mag;
  logic [TAMANYO:0]   w_shift;
  logic [TAMANYO-1:0] w_accu_nx;
  logic [TAMANYO-1:0] w_q_nx;
  logic [TAMANYO-1:0] w_q_fin;
  logic [TAMANYO-1:0] w_coc_fin;
  logic [TAMANYO-1:0] w_rem_mag;
  logic [TAMANYO-1:0] w_rem_fin;

  assign w_num_neg = bus.Signo & bus.Num[TAMANYO-1];
  assign w_den_neg = bus.Signo & bus.Den[TAMANYO-1];
  assign w_num_mag = w_num_neg ? -bus.Num : bus.Num;
  assign w_den_mag = w_den_neg ? -bus.Den : bus.Den;
  // Only -2^(N-1) / -1 overflows; its magnitude quotient already wraps to the required value.
  assign w_ovf_in  = bus.Signo & bus.Num[TAMANYO-1] & ~|bus.Num[TAMANYO-2:0] & &bus.Den;

  // Compare on N+1 bits so divisors up to 2^N-1 work; the difference itself always fits in N bits.
  assign w_shift   = {r_accu, r_q[TAMANYO-1]};
  assign w_ge      = (w_shift >= {1'b0, r_m});
  assign w_accu_nx = w_ge ? (w_shift[TAMANYO-1:0] - r_m) : w_shift[TAMANYO-1:0];
  assign w_q_nx    = {r_q[TAMANYO-2:0], w_ge};
  assign w_q_fin   = (r_signo & (r_sn ^ r_sd)) ? -r_q : r_q;

`ifdef DIVISOR_DIV_CERO_DETECT_EN
  logic r_dz;
  logic r_divcero;
  logic w_den_zero;

  assign w_den_zero  = ~|bus.Den;
  // On the early-exit path the dividend magnitude is still parked in r_q.
  assign w_rem_mag   = r_dz ? r_q : r_accu;
  assign w_coc_fin   = r_dz ? '1 : w_q_fin;
  assign bus.DivCero = r_divcero;
`else
  assign w_rem_mag   = r_accu;
  assign w_coc_fin   = w_q_fin;
  assign bus.DivCero = 1'b0;
`endif

  assign w_rem_fin = (r_signo & r_sn) ? -w_rem_mag : w_rem_mag;

  always_ff @(posedge CLK) begin
    if (!RSTa) begin
      r_state    <= IDLE;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_coc      <= '0;
      r_res      <= '0;
      r_signo    <= 1'b0;
      r_sn       <= 1'b0;
      r_sd       <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_accu     <= '0;
      r_q        <= '0;
      r_m        <= '0;
      r_cnt      <= '0;
`ifdef DIVISOR_DIV_CERO_DETECT_EN
      r_dz       <= 1'b0;
      r_divcero  <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.Start) begin
            r_signo    <= bus.Signo;
            r_sn       <= w_num_neg;
            r_sd       <= w_den_neg;
            r_ovf_pend <= w_ovf_in;
            r_accu     <= '0;
            r_q        <= w_num_mag;
            r_m        <= w_den_mag;
            r_cnt      <= CW'(TAMANYO - 1);
            r_state    <= ITER;
`ifdef DIVISOR_DIV_CERO_DETECT_EN
            r_dz       <= w_den_zero;
            if (w_den_zero) begin
              r_cnt   <= CW'(1);
              r_state <= FIN;
            end
`endif
          end
        end
        ITER: begin
          r_accu <= w_accu_nx;
          r_q    <= w_q_nx;
          if (r_cnt == '0) begin
            r_state <= FIN;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        FIN: begin
          // A non-zero count here is the zero-divisor path waiting one extra cycle.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_coc   <= w_coc_fin;
            r_res   <= w_rem_fin;
            r_ovf   <= r_ovf_pend;
            r_done  <= 1'b1;
            r_state <= IDLE;
`ifdef DIVISOR_DIV_CERO_DETECT_EN
            r_divcero <= r_dz;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.Coc  = r_coc;
  assign bus.Res  = r_res;
  assign bus.Done = r_done;
  assign bus.Ovf  = r_ovf;
  assign bus.Busy = (r_state != IDLE);
endmodule

// File: tb/tb_divisor_parametrico.sv
// Bench for divisor_parametrico at TAMANYO=8: arithmetic reference model checked every cycle plus directed literal cases.
module tb_divisor_parametrico;
  localparam int T   = 8;
  localparam int LAT = T + 1;

  logic CLK = 1'b0;
  logic RSTa;

  divisor_parametrico_if #(.TAMANYO(T)) bus ();

  divisor_parametrico #(.TAMANYO(T)) dut (
    .CLK  (CLK),
    .RSTa (RSTa),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Result as {Ovf, DivCero, Coc, Res} from plain integer division (truncating, remainder follows dividend).
  function automatic logic [17:0] model(input logic sg, input logic [7:0] n, input logic [7:0] d);
    int sn, sd, q, r;
    logic [7:0] qq, rr;
    logic ov, dz;
    ov = 1'b0;
    dz = 1'b0;
    qq = 8'h00;
    rr = 8'h00;
    if (d == 8'd0) begin
`ifdef DIVISOR_DIV_CERO_DETECT_EN
      qq = 8'hFF;
      dz = 1'b1;
`else
      qq = (sg && n[7]) ? 8'h01 : 8'hFF;
`endif
      rr = n;
    end else if (sg) begin
      sn = int'($signed(n));
      sd = int'($signed(d));
      q  = sn / sd;
      r  = sn % sd;
      qq = q[7:0];
      rr = r[7:0];
      ov = (sn == -128) && (sd == -1);
    end else begin
      q  = int'(n) / int'(d);
      r  = int'(n) % int'(d);
      qq = q[7:0];
      rr = r[7:0];
    end
    return {ov, dz, qq, rr};
  endfunction

  function automatic int lat_of(input logic [7:0] d);
`ifdef DIVISOR_DIV_CERO_DETECT_EN
    if (d == 8'd0) return 2;
`endif
    return LAT;
  endfunction

  int          cyc         = 0;
  int          m_done_edge = -1;
  bit          m_active    = 1'b0;
  logic [17:0] m_pend      = '0;
  logic [17:0] m_out       = '0;

  always @(posedge CLK) begin
    cyc++;
    if (!RSTa) begin
      m_active    = 1'b0;
      m_done_edge = -1;
      m_out       = '0;
    end else if (m_active) begin
      if (cyc == m_done_edge) begin
        m_out    = m_pend;
        m_active = 1'b0;
      end
    end else if (bus.Start) begin
      m_pend      = model(bus.Signo, bus.Num, bus.Den);
      m_done_edge = cyc + lat_of(bus.Den);
      m_active    = 1'b1;
    end
  end

  always @(negedge CLK) begin
    if (cyc > 0) begin
      chk($sformatf("cycle%0d {Done,Busy,Ovf,DivCero,Coc,Res}", cyc),
          {bus.Done, bus.Busy, bus.Ovf, bus.DivCero, bus.Coc, bus.Res},
          {(cyc == m_done_edge), m_active, m_out});
    end
  end

  // Called at the negedge right after the accept edge; optionally pokes Start while busy.
  task automatic wait_done(output int lat, output int busy_n, input bit poke);
    lat    = 0;
    busy_n = 0;
    while (!bus.Done && lat < 40) begin
      if (bus.Busy) busy_n++;
      if (poke) begin
        bus.Start = (lat == 2 || lat == 5 || lat == 8);
        if (bus.Start) begin
          bus.Num = 8'h55;
          bus.Den = 8'h03;
        end
      end
      @(negedge CLK);
      lat++;
    end
    if (poke) bus.Start = 1'b0;
  endtask

  task automatic do_op(input logic sg, input logic [7:0] n, input logic [7:0] d,
                       input logic [7:0] eq, input logic [7:0] er, input logic eovf,
                       input logic edz, input int elat, input bit poke, input string nm);
    int lat, bn;
    bus.Start = 1'b1;
    bus.Signo = sg;
    bus.Num   = n;
    bus.Den   = d;
    @(negedge CLK);
    bus.Start = 1'b0;
    bus.Num   = ~n;
    bus.Den   = d + 8'd1;
    wait_done(lat, bn, poke);
    chk({nm, "_coc"}, bus.Coc, eq);
    chk({nm, "_res"}, bus.Res, er);
    chk({nm, "_ovf"}, bus.Ovf, eovf);
    chk({nm, "_divcero"}, bus.DivCero, edz);
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_busy_cycles"}, bn, elat);
  endtask

  int lat, bn, dseen;

  initial begin
    RSTa      = 1'b0;
    bus.Start = 1'b1;
    bus.Signo = 1'b0;
    bus.Num   = 8'hAA;
    bus.Den   = 8'h03;
    repeat (3) @(negedge CLK);
    chk("reset_coc", bus.Coc, 8'h00);
    chk("reset_res", bus.Res, 8'h00);
    chk("reset_done", bus.Done, 1'b0);
    chk("reset_busy", bus.Busy, 1'b0);
    chk("reset_ovf", bus.Ovf, 1'b0);
    chk("reset_divcero", bus.DivCero, 1'b0);
    bus.Start = 1'b0;
    RSTa      = 1'b1;

    chk("model_u200_7", model(1'b0, 8'd200, 8'd7), {2'b00, 8'd28, 8'd4});
    chk("model_sF9_02", model(1'b1, 8'hF9, 8'h02), {2'b00, 8'hFD, 8'hFF});
    chk("model_s80_FF", model(1'b1, 8'h80, 8'hFF), {2'b10, 8'h80, 8'h00});
    chk("model_sF8_FD", model(1'b1, 8'hF8, 8'hFD), {2'b00, 8'h02, 8'hFE});

    @(negedge CLK);
    do_op(1'b0, 8'd200, 8'd7,  8'd28,  8'd4,  1'b0, 1'b0, LAT, 1'b0, "u200_7");
    do_op(1'b1, 8'hF9,  8'h02, 8'hFD,  8'hFF, 1'b0, 1'b0, LAT, 1'b0, "sF9_02");
    do_op(1'b1, 8'h80,  8'hFF, 8'h80,  8'h00, 1'b1, 1'b0, LAT, 1'b0, "s80_FF");
`ifdef DIVISOR_DIV_CERO_DETECT_EN
    do_op(1'b0, 8'd9,   8'd0,  8'hFF,  8'h09, 1'b0, 1'b1, 2,   1'b0, "u9_0");
    do_op(1'b1, 8'hF9,  8'h00, 8'hFF,  8'hF9, 1'b0, 1'b1, 2,   1'b0, "sF9_0");
`else
    do_op(1'b0, 8'd9,   8'd0,  8'hFF,  8'h09, 1'b0, 1'b0, LAT, 1'b0, "u9_0");
    do_op(1'b1, 8'hF9,  8'h00, 8'h01,  8'hF9, 1'b0, 1'b0, LAT, 1'b0, "sF9_0");
`endif
    do_op(1'b0, 8'hFF,  8'hFF, 8'h01,  8'h00, 1'b0, 1'b0, LAT, 1'b0, "uFF_FF");
    do_op(1'b0, 8'hFE,  8'hFF, 8'h00,  8'hFE, 1'b0, 1'b0, LAT, 1'b0, "uFE_FF");
    do_op(1'b0, 8'hFF,  8'h01, 8'hFF,  8'h00, 1'b0, 1'b0, LAT, 1'b0, "uFF_01");
    do_op(1'b1, 8'h07,  8'hFE, 8'hFD,  8'h01, 1'b0, 1'b0, LAT, 1'b0, "s07_FE");
    do_op(1'b1, 8'hF8,  8'hFD, 8'h02,  8'hFE, 1'b0, 1'b0, LAT, 1'b0, "sF8_FD");
    do_op(1'b1, 8'h80,  8'h01, 8'h80,  8'h00, 1'b0, 1'b0, LAT, 1'b0, "s80_01");
    do_op(1'b0, 8'd100, 8'd9,  8'd11,  8'd1,  1'b0, 1'b0, LAT, 1'b1, "u100_9_pokes");

    // Reset four iterations into an operation: everything clears and no Done follows.
    bus.Start = 1'b1;
    bus.Signo = 1'b0;
    bus.Num   = 8'd100;
    bus.Den   = 8'd3;
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (4) @(negedge CLK);
    RSTa = 1'b0;
    @(negedge CLK);
    RSTa = 1'b1;
    chk("midrst_coc", bus.Coc, 8'h00);
    chk("midrst_res", bus.Res, 8'h00);
    chk("midrst_busy", bus.Busy, 1'b0);
    chk("midrst_done", bus.Done, 1'b0);
    dseen = 0;
    repeat (12) begin
      @(negedge CLK);
      if (bus.Done) dseen++;
    end
    chk("midrst_no_done", dseen, 0);
    do_op(1'b0, 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b0, LAT, 1'b0, "after_rst_u200_7");

    // Start held high: second operation is accepted in the Done cycle of the first.
    bus.Start = 1'b1;
    bus.Signo = 1'b0;
    bus.Num   = 8'd50;
    bus.Den   = 8'd6;
    @(negedge CLK);
    bus.Num = 8'd77;
    bus.Den = 8'd5;
    wait_done(lat, bn, 1'b0);
    chk("b2b_a_coc", bus.Coc, 8'd8);
    chk("b2b_a_res", bus.Res, 8'd2);
    chk("b2b_a_latency", lat, LAT);
    @(negedge CLK);
    bus.Start = 1'b0;
    bus.Num   = 8'd0;
    bus.Den   = 8'd0;
    wait_done(lat, bn, 1'b0);
    chk("b2b_b_coc", bus.Coc, 8'd15);
    chk("b2b_b_res", bus.Res, 8'd2);
    chk("b2b_b_latency", lat, LAT);

    repeat (3) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
